// File: rtl/lfsr_rng.sv
// Galois-LFSR pseudo-random word source with seed loading, zero-state recovery
// and a valid/ready output register that advances only when a word is accepted.
module lfsr_rng #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hF5D2,
    parameter int               OUT_W = 16,
    parameter int               CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             seed_fixed,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] state_r;
    logic             out_valid_r;
    logic [OUT_W-1:0] out_data_r;
    logic             seed_fixed_r;
    logic [CNT_W-1:0] word_cnt_r;

    logic             produce_s;
    logic             lockout_s;
    logic [WIDTH-1:0] src_s;
    logic [WIDTH-1:0] load_val_s;
    logic             load_zero_s;

    // One Galois step: logical right shift, feedback mask applied when bit 0 falls out.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0] shifted;
        shifted = {1'b0, cur[WIDTH-1:1]};
        if (cur[0]) begin
            lfsr_step = shifted ^ TAPS;
        end else begin
            lfsr_step = shifted;
        end
    endfunction

    // Handshake decode, zero-state substitution and seed sanitising.
    always_comb begin
        produce_s   = en & ~seed_load & (~out_valid_r | out_ready);
        lockout_s   = (state_r == ZERO_W);
        load_zero_s = (seed_in == ZERO_W);
        if (lockout_s) begin
            src_s = SEED;
        end else begin
            src_s = state_r;
        end
        if (load_zero_s) begin
            load_val_s = SEED;
        end else begin
            load_val_s = seed_in;
        end
    end

    // State, output register and word counter; seed load outranks generation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= SEED;
            out_valid_r  <= 1'b0;
            out_data_r   <= {OUT_W{1'b0}};
            seed_fixed_r <= 1'b0;
            word_cnt_r   <= {CNT_W{1'b0}};
        end else if (seed_load) begin
            state_r      <= load_val_s;
            out_valid_r  <= 1'b0;
            seed_fixed_r <= load_zero_s;
            word_cnt_r   <= {CNT_W{1'b0}};
        end else if (produce_s) begin
            state_r      <= lfsr_step(src_s);
            out_valid_r  <= 1'b1;
            out_data_r   <= src_s[OUT_W-1:0];
            seed_fixed_r <= lockout_s;
            word_cnt_r   <= word_cnt_r + ONE_C;
        end else begin
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            seed_fixed_r <= 1'b0;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign seed_fixed = seed_fixed_r;
    assign word_cnt   = word_cnt_r;

endmodule
